// File: rtl/wb_commit_checker.sv
// wb_commit_checker: self-check monitor for CPU directed tests.
// It watches the writeback commit stream for an ordered list of trigger PCs.
// On each trigger it reads one architectural register and compares it with an
// expected value. The verdict (pass, mismatch or watchdog timeout) is sticky
// until reset.
module wb_commit_checker #(
  parameter int NUM_CHECKS = 4,
  parameter int IDX_W      = 2,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int RIDX_W     = 5,
  parameter int TIMEOUT    = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [PC_W-1:0]   cfg_pc,
  input  logic [RIDX_W-1:0] cfg_ridx,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [IDX_W:0]    cfg_num,
  input  logic              arm,
  input  logic              wb_valid,
  input  logic [PC_W-1:0]   wb_pc,
  output logic [RIDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [1:0]        fail_code,
  output logic [DATA_W-1:0] fail_act,
  output logic [31:0]       cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  CODE_NONE     = 2'd0;
  localparam logic [1:0]  CODE_MISMATCH = 2'd1;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'd2;
  localparam logic [1:0]  CODE_BAD_NUM  = 2'd3;
  localparam bit          TMO_EN_C      = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LIM_C     = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    cur_r, cur_s;
  logic [IDX_W:0]      num_r, num_s;
  logic [PC_W-1:0]     pc_r   [NUM_CHECKS];
  logic [PC_W-1:0]     pc_s   [NUM_CHECKS];
  logic [RIDX_W-1:0]   ridx_r [NUM_CHECKS];
  logic [RIDX_W-1:0]   ridx_s [NUM_CHECKS];
  logic [DATA_W-1:0]   exp_r  [NUM_CHECKS];
  logic [DATA_W-1:0]   exp_s  [NUM_CHECKS];
  logic [31:0]         cycles_r, cycles_s, cyc_inc_s;
  logic [RIDX_W-1:0]   rf_raddr_r, rf_raddr_s;
  logic                busy_r, busy_s, done_r, done_s;
  logic                pass_r, pass_s, fail_r, fail_s;
  logic [IDX_W-1:0]    fail_idx_r, fail_idx_s;
  logic [1:0]          fail_code_r, fail_code_s;
  logic [DATA_W-1:0]   fail_act_r, fail_act_s;
  logic                wr_en_s, num_bad_s, last_s, hit_s, match_s, tmo_hit_s;

  assign wr_en_s   = (state_r == ST_IDLE) && cfg_we &&
                     ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_CHECKS));
  assign num_bad_s = (cfg_num == {(IDX_W+1){1'b0}}) ||
                     (cfg_num > (IDX_W+1)'(NUM_CHECKS));
  assign last_s    = ({1'b0, cur_r} == (num_r - (IDX_W+1)'(1'b1)));
  assign hit_s     = wb_valid && (wb_pc == pc_r[cur_r]);
  assign match_s   = (rf_rdata == exp_r[cur_r]);
  assign tmo_hit_s = TMO_EN_C && (cycles_r >= TMO_LIM_C);
  assign cyc_inc_s = (cycles_r == 32'hFFFF_FFFF) ? cycles_r : (cycles_r + 32'd1);

  // Entry table next value: one entry may be rewritten while idle
  always_comb begin
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (wr_en_s && (cfg_idx == IDX_W'(i))) begin
        pc_s[i]   = cfg_pc;
        ridx_s[i] = cfg_ridx;
        exp_s[i]  = cfg_exp;
      end else begin
        pc_s[i]   = pc_r[i];
        ridx_s[i] = ridx_r[i];
        exp_s[i]  = exp_r[i];
      end
    end
  end

  // Check sequencer next state, progress counter and verdict
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    num_s       = num_r;
    cycles_s    = cycles_r;
    pass_s      = pass_r;
    fail_s      = fail_r;
    fail_idx_s  = fail_idx_r;
    fail_code_s = fail_code_r;
    fail_act_s  = fail_act_r;
    case (state_r)
      ST_IDLE: begin
        if (arm && num_bad_s) begin
          state_s     = ST_DONE;
          fail_s      = 1'b1;
          fail_code_s = CODE_BAD_NUM;
        end else if (arm) begin
          state_s  = ST_WAIT;
          num_s    = cfg_num;
          cur_s    = {IDX_W{1'b0}};
          cycles_s = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // The watchdog outranks a trigger seen in the same cycle; only a
        // register compare in progress may beat it.
        if (tmo_hit_s) begin
          state_s     = ST_DONE;
          fail_s      = 1'b1;
          fail_code_s = CODE_TIMEOUT;
          fail_idx_s  = cur_r;
        end else if (hit_s) begin
          state_s  = ST_READ;
          cycles_s = cyc_inc_s;
        end else begin
          cycles_s = cyc_inc_s;
        end
      end
      ST_READ: begin
        if (match_s && last_s) begin
          state_s     = ST_DONE;
          pass_s      = 1'b1;
          fail_code_s = CODE_NONE;
        end else if (match_s) begin
          state_s  = ST_WAIT;
          cur_s    = cur_r + IDX_W'(1'b1);
          cycles_s = cyc_inc_s;
        end else begin
          state_s     = ST_DONE;
          fail_s      = 1'b1;
          fail_code_s = CODE_MISMATCH;
          fail_idx_s  = cur_r;
          fail_act_s  = rf_rdata;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    rf_raddr_s = ridx_s[cur_s];
    busy_s     = (state_s == ST_WAIT) || (state_s == ST_READ);
    done_s     = (state_s == ST_DONE);
  end

  // State, table and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cur_r   <= {IDX_W{1'b0}};
      num_r   <= {(IDX_W+1){1'b0}};
      for (int i = 0; i < NUM_CHECKS; i++) begin
        pc_r[i]   <= {PC_W{1'b0}};
        ridx_r[i] <= {RIDX_W{1'b0}};
        exp_r[i]  <= {DATA_W{1'b0}};
      end
      cycles_r    <= 32'd0;
      rf_raddr_r  <= {RIDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_idx_r  <= {IDX_W{1'b0}};
      fail_code_r <= 2'd0;
      fail_act_r  <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      num_r       <= num_s;
      pc_r        <= pc_s;
      ridx_r      <= ridx_s;
      exp_r       <= exp_s;
      cycles_r    <= cycles_s;
      rf_raddr_r  <= rf_raddr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_r      <= fail_s;
      fail_idx_r  <= fail_idx_s;
      fail_code_r <= fail_code_s;
      fail_act_r  <= fail_act_s;
    end
  end

  assign rf_raddr  = rf_raddr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign fail_idx  = fail_idx_r;
  assign fail_code = fail_code_r;
  assign fail_act  = fail_act_r;
  assign cycles    = cycles_r;

endmodule

// File: tb/tb_wb_commit_checker.sv
// Bench for wb_commit_checker: directed scenarios plus randomized runs.
// For each run the expected outcome is derived by scanning the planned
// commit stream against the ordered check list.
module tb_wb_commit_checker;
  localparam int NC = 4;
  localparam int IW = 2;
  localparam int PW = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [PW-1:0] cfg_pc = '0;
  logic [RW-1:0] cfg_ridx = '0;
  logic [DW-1:0] cfg_exp = '0;
  logic [IW:0]   cfg_num = '0;
  logic          arm = 1'b0;
  logic          wb_valid = 1'b0;
  logic [PW-1:0] wb_pc = '0;
  logic [RW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          busy, done, pass, fail;
  logic [IW-1:0] fail_idx;
  logic [1:0]    fail_code;
  logic [DW-1:0] fail_act;
  logic [31:0]   cycles;

  logic [DW-1:0] rf_mem [32];
  assign rf_rdata = rf_mem[rf_raddr];

  wb_commit_checker #(
    .NUM_CHECKS(NC), .IDX_W(IW), .PC_W(PW), .DATA_W(DW), .RIDX_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
    .cfg_ridx(cfg_ridx), .cfg_exp(cfg_exp), .cfg_num(cfg_num), .arm(arm),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_idx(fail_idx),
    .fail_code(fail_code), .fail_act(fail_act), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference copy of the check table and the planned commit stream
  logic [PW-1:0] m_pc   [NC];
  logic [RW-1:0] m_ridx [NC];
  logic [DW-1:0] m_exp  [NC];
  bit            st_valid [64];
  logic [PW-1:0] st_pc    [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      m_pc[i] = '0; m_ridx[i] = '0; m_exp[i] = '0;
    end
  endtask

  task automatic clear_stream();
    for (int k = 0; k < 64; k++) begin
      st_valid[k] = 1'b0; st_pc[k] = '0;
    end
  endtask

  // Called and left at a falling edge
  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; arm = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic prog(input int idx, input logic [PW-1:0] pc, input logic [RW-1:0] ridx,
                      input logic [DW-1:0] ev);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_pc = pc; cfg_ridx = ridx; cfg_exp = ev;
    @(negedge clk);
    cfg_we = 1'b0;
    m_pc[idx] = pc; m_ridx[idx] = ridx; m_exp[idx] = ev;
  endtask

  task automatic put(input int k, input logic [PW-1:0] pc);
    st_valid[k] = 1'b1; st_pc[k] = pc;
  endtask

  // Arm (optionally with a same-cycle entry write), play the stream and
  // compare every cycle until one cycle past the expected verdict.
  task automatic run_check(input logic [IW:0] num, input bit wr_at_arm, input int widx,
                           input logic [PW-1:0] wpc, input logic [RW-1:0] wridx,
                           input logic [DW-1:0] wexp);
    logic [RW-1:0] raddr_q [64];
    logic [31:0]   e_pass, e_fail, e_code, e_idx, e_act, e_cyc;
    logic [DW-1:0] val;
    int  dec, cur, k;
    bit  reading, fin;
    if (wr_at_arm) begin
      cfg_we = 1'b1; cfg_idx = IW'(widx); cfg_pc = wpc; cfg_ridx = wridx; cfg_exp = wexp;
      m_pc[widx] = wpc; m_ridx[widx] = wridx; m_exp[widx] = wexp;
    end
    arm = 1'b1; cfg_num = num;
    e_pass = 0; e_fail = 0; e_code = 0; e_idx = 0; e_act = 0; e_cyc = 0;
    cur = 0; dec = -1;
    if (num == 0 || int'(num) > NC) begin
      e_fail = 1; e_code = 3;
    end else begin
      reading = 1'b0; fin = 1'b0; k = 0;
      while (!fin) begin
        raddr_q[k] = m_ridx[cur];
        if (reading) begin
          val = rf_mem[m_ridx[cur]];
          if (val == m_exp[cur]) begin
            if (cur == int'(num) - 1) begin
              fin = 1'b1; e_pass = 1;
            end else begin
              cur++; reading = 1'b0;
            end
          end else begin
            fin = 1'b1; e_fail = 1; e_code = 1; e_idx = 32'(cur); e_act = val;
          end
        end else if (k >= TO - 1) begin
          fin = 1'b1; e_fail = 1; e_code = 2; e_idx = 32'(cur);
        end else if (st_valid[k] && st_pc[k] == m_pc[cur]) begin
          reading = 1'b1;
        end
        if (!fin) k++;
      end
      dec = k; e_cyc = 32'(k);
    end
    raddr_q[dec + 1] = m_ridx[cur];
    @(negedge clk);
    arm = 1'b0; cfg_we = 1'b0;
    for (int c = 0; c <= dec + 1; c++) begin
      chk("busy", 32'(busy), (c <= dec) ? 32'd1 : 32'd0);
      chk("done", 32'(done), (c > dec) ? 32'd1 : 32'd0);
      chk("rf_raddr", 32'(rf_raddr), 32'(raddr_q[c]));
      if (c == dec + 1) begin
        chk("pass", 32'(pass), e_pass);
        chk("fail", 32'(fail), e_fail);
        chk("fail_code", 32'(fail_code), e_code);
        chk("fail_idx", 32'(fail_idx), e_idx);
        chk("fail_act", fail_act, e_act);
        chk("cycles", cycles, e_cyc);
      end
      wb_valid = st_valid[c];
      wb_pc    = st_pc[c];
      @(negedge clk);
    end
    wb_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_fidx"}, 32'(fail_idx), 32'd0);
    chk({tag, "_fcode"}, 32'(fail_code), 32'd0);
    chk({tag, "_fact"}, fail_act, 32'd0);
    chk({tag, "_cycles"}, cycles, 32'd0);
    chk({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
  endtask

  initial begin
    logic [IW:0] rnum;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    clear_model();
    clear_stream();
    @(negedge clk);
    do_reset();
    chk_all_zero("rst");

    // Single entry, correct value
    prog(0, 32'h1c000060, 5'd5, 32'h5a);
    rf_mem[5] = 32'h5a;
    clear_stream(); put(0, 32'h1c000060);
    run_check(3'd1, 1'b0, 0, '0, '0, '0);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_code", 32'(fail_code), 32'd0);
    chk("t1_cycles", cycles, 32'd1);

    // Single entry, wrong value
    do_reset();
    prog(0, 32'h1c000060, 5'd5, 32'h5a);
    rf_mem[5] = 32'h5b;
    run_check(3'd1, 1'b0, 0, '0, '0, '0);
    chk("t2_fail", 32'(fail), 32'd1);
    chk("t2_code", 32'(fail_code), 32'd1);
    chk("t2_idx", 32'(fail_idx), 32'd0);
    chk("t2_act", fail_act, 32'h5b);

    // Three ordered entries, commits out of order
    do_reset();
    prog(0, 32'h1c000010, 5'd1, 32'h11);
    prog(1, 32'h1c000020, 5'd2, 32'h22);
    prog(2, 32'h1c000030, 5'd3, 32'h33);
    rf_mem[1] = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h33;
    clear_stream();
    put(0, 32'h1c000020); put(2, 32'h1c000010); put(4, 32'h1c000030);
    put(6, 32'h1c000020); put(8, 32'h1c000030);
    run_check(3'd3, 1'b0, 0, '0, '0, '0);
    chk("t3_pass", 32'(pass), 32'd1);
    chk("t3_cycles", cycles, 32'd9);

    // Watchdog with no matching commit
    do_reset();
    prog(0, 32'h1c000060, 5'd5, 32'h5a);
    clear_stream();
    run_check(3'd1, 1'b0, 0, '0, '0, '0);
    chk("t4_code", 32'(fail_code), 32'd2);
    chk("t4_cycles", cycles, 32'd49);

    // Bad entry counts
    do_reset();
    run_check(3'd0, 1'b0, 0, '0, '0, '0);
    chk("t5_code", 32'(fail_code), 32'd3);
    do_reset();
    run_check(3'd5, 1'b0, 0, '0, '0, '0);
    chk("t5b_done", 32'(done), 32'd1);

    // Reset while waiting, then re-arm and pass
    do_reset();
    prog(0, 32'h1c000060, 5'd5, 32'h5a);
    rf_mem[5] = 32'h5a;
    arm = 1'b1; cfg_num = 3'd1;
    @(negedge clk);
    arm = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd1);
    do_reset();
    chk_all_zero("midrst");
    prog(0, 32'h1c000060, 5'd5, 32'h5a);
    clear_stream(); put(1, 32'h1c000060);
    run_check(3'd1, 1'b0, 0, '0, '0, '0);
    chk("t6_pass", 32'(pass), 32'd1);

    // Write and arm together; then writes and arm in DONE are ignored
    do_reset();
    prog(0, 32'h1c000100, 5'd9, 32'h77);
    rf_mem[9] = 32'h77;
    clear_stream(); put(1, 32'h1c000100); put(3, 32'h1c000200);
    run_check(3'd1, 1'b1, 0, 32'h1c000200, 5'd9, 32'h77);
    chk("t7_pass", 32'(pass), 32'd1);
    chk("t7_cycles", cycles, 32'd4);
    cfg_we = 1'b1; cfg_idx = '0; cfg_pc = 32'h1c000300; cfg_ridx = 5'd17; cfg_exp = 32'h1;
    arm = 1'b1; cfg_num = 3'd1;
    @(negedge clk);
    cfg_we = 1'b0; arm = 1'b0;
    @(negedge clk);
    chk("t7_probe_raddr", 32'(rf_raddr), 32'd9);
    chk("t7_probe_done", 32'(done), 32'd1);
    chk("t7_probe_busy", 32'(busy), 32'd0);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      do_reset();
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      for (int i = 0; i < NC; i++)
        prog(i, 32'h1c000000 + 32'($urandom_range(0, 5)) * 32'd4,
             RW'($urandom_range(0, 31)), $urandom);
      for (int i = 0; i < NC; i++)
        rf_mem[m_ridx[i]] = ($urandom_range(0, 99) < 85) ? m_exp[i] : (m_exp[i] ^ 32'h1);
      clear_stream();
      for (int k = 0; k < 56; k++) begin
        st_valid[k] = ($urandom_range(0, 1) == 1);
        st_pc[k]    = 32'h1c000000 + 32'($urandom_range(0, 5)) * 32'd4;
      end
      rnum = ($urandom_range(0, 9) == 0) ? (IW+1)'($urandom_range(0, 7))
                                         : (IW+1)'($urandom_range(1, 4));
      run_check(rnum, 1'b0, 0, '0, '0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
